// File: rtl/mem_responder.sv
// Single-ported 16-bit word memory responder with WAIT_CYCLES wait states and a one-cycle ready pulse.
// Optional misaligned-access detection is enabled with the MEM_ALIGN_CHECK_EN macro.
module mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_mem_ready,
    output logic        o_mem_busy,
    output logic        o_mem_err
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_d;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [15:0]           r_wdata;
    logic                  r_write;
    logic [15:0]           r_rdata;
    logic [15:0]           r_mem [Depth];

    logic                  w_req;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic [DEPTH_LOG2-1:0] w_op_idx;
    logic [15:0]           w_op_wdata;
    logic                  w_op_write;
    logic                  w_op_mis;
    logic                  w_unused;

    assign w_req    = i_mem_read | i_mem_write;
    assign w_accept = (r_state == StIdle) && w_req;
    // Only a subset of address bits selects the word.
    assign w_unused = ^i_addr;

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misalign;
    logic r_err;
    assign o_mem_err = r_err;
`else
    assign o_mem_err = 1'b0;
`endif

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_enter_resp = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        w_state_d    = StResp;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_d = StWait;
                    end
                end
            end
            StWait: begin
                w_cnt_d = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_d    = StResp;
                    w_enter_resp = 1'b1;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // With zero wait states RESP is entered straight from IDLE, before anything is latched.
    always_comb begin
        w_op_idx   = r_idx;
        w_op_wdata = r_wdata;
        w_op_write = r_write;
        w_op_mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        w_op_mis   = r_misalign;
`endif
        if (r_state == StIdle) begin
            w_op_idx   = i_addr[DEPTH_LOG2:1];
            w_op_wdata = i_wdata;
            w_op_write = i_mem_write;
`ifdef MEM_ALIGN_CHECK_EN
            w_op_mis   = i_addr[0];
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 16'h0000;
            r_write <= 1'b0;
            r_rdata <= 16'h0000;
`ifdef MEM_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_idx   <= i_addr[DEPTH_LOG2:1];
                r_wdata <= i_wdata;
                r_write <= i_mem_write;
`ifdef MEM_ALIGN_CHECK_EN
                r_misalign <= i_addr[0];
`endif
            end
            if (w_enter_resp) begin
                if (!w_op_write && !w_op_mis) begin
                    r_rdata <= r_mem[w_op_idx];
                end
`ifdef MEM_ALIGN_CHECK_EN
                r_err <= w_op_mis;
`endif
            end
        end
    end

    // Array is never cleared; a write cut off by reset never reaches it.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_enter_resp && w_op_write && !w_op_mis) begin
            r_mem[w_op_idx] <= w_op_wdata;
        end
    end

    assign o_rdata     = r_rdata;
    assign o_mem_ready = (r_state == StResp);
    assign o_mem_busy  = (r_state != StIdle);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a 2-wait-state instance plus a 0-wait-state instance on
// shared request inputs; expected read data and error flags come from a small memory model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;
    logic [15:0] rdata0;
    logic        ready0;
    logic        busy0;
    logic        err0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_read  (rd),
        .i_mem_write (wr),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_mem_ready (ready),
        .o_mem_busy  (busy),
        .o_mem_err   (err)
    );

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_read  (rd),
        .i_mem_write (wr),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata0),
        .o_mem_ready (ready0),
        .o_mem_busy  (busy0),
        .o_mem_err   (err0)
    );

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit AlignEn = 1'b1;
`else
    localparam bit AlignEn = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mdl [256];
    logic [15:0] last_rd  = 16'h0000;
    logic        last_err = 1'b0;
    int          n_checks = 0;
    int          n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic void push_exp(input logic rd_i, input logic wr_i, input logic [15:0] a,
                                     input logic [15:0] d);
        logic mis;
        mis = AlignEn && a[0];
        if (wr_i) begin
            if (!mis) mdl[a[8:1]] = d;
        end else if (rd_i && !mis) begin
            last_rd = mdl[a[8:1]];
        end
        last_err = mis;
        sb_q.push_back('{rdata: last_rd, err: last_err});
    endfunction

    task automatic req(input logic rd_i, input logic wr_i, input logic [15:0] a,
                       input logic [15:0] d, input bit chk0);
        exp_t        e;
        int          lat;
        int          lat0;
        int          busy_n;
        logic [15:0] rd_start;
        bit          moved;
        @(negedge clk);
        rd = rd_i; wr = wr_i; addr = a; wdata = d;
        push_exp(rd_i, wr_i, a, d);
        e = sb_q[$];
        rd_start = rdata; lat = 0; lat0 = 0; busy_n = 0; moved = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (ready0 && lat0 == 0) begin
                lat0 = n;
                if (chk0) begin
                    check("rdata0", rdata0, e.rdata);
                    check("err0", err0, e.err);
                end
            end
            if (ready) lat = n;
            else if (rdata !== rd_start) moved = 1'b1;
        end
        rd = 1'b0; wr = 1'b0;
        check("latency", lat, 3);
        check("busy_cycles", busy_n, 3);
        e = sb_q.pop_front();
        check("rdata", rdata, e.rdata);
        check("err", err, e.err);
        if (!(rd_i && !wr_i)) check("rdata_hold", moved, 0);
        if (chk0) check("latency0", lat0, 1);
        @(negedge clk);
        check("ready_pulse", {busy, ready}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int          pulses;
        int          pos [3];
        int          stray;
        exp_t        e;
        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0000; wdata = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 16'h0000);
        rst = 1'b1;

        req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b1);
        req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
        req(1'b1, 1'b1, 16'h0004, 16'h1234, 1'b1);
        req(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1);
        req(1'b0, 1'b1, 16'h1210, 16'hCAFE, 1'b1);
        req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);

        // Held read: three back-to-back accesses expected at a 4-cycle cadence.
        @(negedge clk);
        rd = 1'b1; addr = 16'h0004;
        for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b0, 16'h0004, 16'h0000);
        pulses = 0;
        for (int i = 0; i < 3; i++) pos[i] = 0;
        @(posedge clk);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (ready) begin
                if (pulses < 3) pos[pulses] = n;
                pulses++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("held_rdata", rdata, e.rdata);
                end
            end
            if (n == 10) rd = 1'b0;
        end
        check("held_pulses", pulses, 3);
        check("held_pos1", pos[0], 3);
        check("held_pos2", pos[1], 7);
        check("held_pos3", pos[2], 11);
        check("held_sb_empty", sb_q.size(), 0);

        // Reset in the first WAIT cycle discards the pending write.
        req(1'b0, 1'b1, 16'h0002, 16'h5555, 1'b0);
        @(negedge clk);
        wr = 1'b1; addr = 16'h0002; wdata = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_wait", busy, 1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; wr = 1'b0;
        last_rd = 16'h0000; last_err = 1'b0;
        check("rst2_rdata", rdata, 16'h0000);
        check("rst2_busy", busy, 0);
        check("rst2_err", err, 0);
        stray = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ready) stray++;
        end
        check("rst2_no_ready", stray, 0);
        req(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);

        // Misaligned write over word 1, then an aligned read of the same word.
        req(1'b0, 1'b1, 16'h0003, 16'hFFFF, 1'b0);
        req(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
